// File: rtl/fir_sm_fifo_pkg.sv
// -----------------------------------------------------------------------------
// fir_sm_fifo_pkg
// Shared constants, sizing helper and entry layout for the FIR output-side
// stream buffer (fir_sm_fifo and fir_sm_fifo_mem).
// -----------------------------------------------------------------------------
package fir_sm_fifo_pkg;

  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_DATA_W = 32;

  // Occupancy width: one bit more than the pointer so that "full" (== depth)
  // can be represented.
  function automatic int CNT_W(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // One buffered beat at the default data width. Blocks built at other
  // widths declare the same layout locally from their own width parameter.
  typedef struct packed {
    logic                      last;
    logic [DEFAULT_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/fir_sm_fifo_mem.sv
// -----------------------------------------------------------------------------
// fir_sm_fifo_mem
// Register array backing the stream buffer: one synchronous write port and
// one asynchronous (combinational) read port.
//
// Ports:
//   clk    in             clock
//   rst_n  in             async active-low reset, clears every entry
//   we     in             write enable
//   waddr  in  ADDR_W     write address
//   wdata  in  ENTRY_W    write data
//   raddr  in  ADDR_W     read address
//   rdata  out ENTRY_W    contents of entry raddr
// -----------------------------------------------------------------------------
module fir_sm_fifo_mem #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 33,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // NOTE: the array is reset so the head output reads 0 (never X) out of
  // reset; this costs a reset net on every entry and rules out RAM macros.
  // NOTE: sequential state is only ever assigned with <= so every flop
  // samples its inputs as they were before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_sm_fifo.sv
// -----------------------------------------------------------------------------
// fir_sm_fifo
// AXI-Stream buffer between the FIR engine's sm_* master and the Wishbone
// bridge. First-word-fallthrough circular buffer with registered ready/valid,
// occupancy output and a sticky end-of-frame flag.
//
// Ports:
//   axis_clk    in                 clock
//   axis_rst_n  in                 async active-low reset
//   s_tvalid    in                 upstream beat valid
//   s_tready    out                buffer not full (registered)
//   s_tdata     in  pDATA_WIDTH    upstream data
//   s_tlast     in                 upstream end-of-frame
//   m_tvalid    out                buffer not empty (registered)
//   m_tready    in                 downstream read strobe
//   m_tdata     out pDATA_WIDTH    head data
//   m_tlast     out                head end-of-frame
//   flush       in                 synchronous clear of pointers/count/flags
//   count       out pCNT_WIDTH     occupancy
//   frame_done  out                sticky, set when a tlast beat is popped
//   frame_clr   in                 clears frame_done (a same-cycle set wins)
//
// Optional build macro FIR_SM_FIFO_STATS_EN adds:
//   beat_cnt    out 16             pops since reset/flush, saturating
//   ovf_seen    out                sticky, upstream was held off while full
// -----------------------------------------------------------------------------
module fir_sm_fifo
  import fir_sm_fifo_pkg::*;
#(
  parameter int pDATA_WIDTH = DEFAULT_DATA_W,
  parameter int pDEPTH      = DEFAULT_DEPTH,
  parameter int pCNT_WIDTH  = CNT_W(pDEPTH)
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic                   flush,
  output logic [pCNT_WIDTH-1:0]  count,
  output logic                   frame_done,
`ifdef FIR_SM_FIFO_STATS_EN
  output logic [15:0]            beat_cnt,
  output logic                   ovf_seen,
`endif
  input  logic                   frame_clr
);

  localparam int PTR_W = CNT_W(pDEPTH) - 1;

  typedef struct packed {
    logic                   last;
    logic [pDATA_WIDTH-1:0] data;
  } fifo_entry_t;

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [pCNT_WIDTH-1:0] count_nxt;
  logic                  push, pop;
  fifo_entry_t           wr_entry, rd_entry;

  // Handshakes use the registered flags, so ready/valid never depend
  // combinationally on the other side of the buffer.
  assign push = s_tvalid & s_tready;
  assign pop  = m_tvalid & m_tready;

  assign wr_entry = '{last: s_tlast, data: s_tdata};

  // A push in the flush cycle is dropped, so the write is gated here too.
  fir_sm_fifo_mem #(
    .DEPTH   (pDEPTH),
    .ENTRY_W ($bits(fifo_entry_t)),
    .ADDR_W  (PTR_W)
  ) u_mem (
    .clk   (axis_clk),
    .rst_n (axis_rst_n),
    .we    (push & ~flush),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign m_tdata = rd_entry.data;
  assign m_tlast = rd_entry.last;

  // NOTE: the default assignment on entry keeps this block free of latches
  // whichever branch is taken.
  always_comb begin
    count_nxt = count;
    if (flush)             count_nxt = '0;
    else if (push && !pop) count_nxt = count + pCNT_WIDTH'(1);
    else if (pop && !push) count_nxt = count - pCNT_WIDTH'(1);
  end

  // Pointers are log2(depth) wide, so +1 wraps modulo depth by itself.
  // The ready/valid flags are registered from the next occupancy.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      s_tready <= 1'b1;
      m_tvalid <= 1'b0;
    end else begin
      count    <= count_nxt;
      s_tready <= (count_nxt != pCNT_WIDTH'(pDEPTH));
      m_tvalid <= (count_nxt != '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n)          frame_done <= 1'b0;
    else if (flush)           frame_done <= 1'b0;
    else if (pop && m_tlast)  frame_done <= 1'b1;
    else if (frame_clr)       frame_done <= 1'b0;
  end

`ifdef FIR_SM_FIFO_STATS_EN
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      beat_cnt <= '0;
      ovf_seen <= 1'b0;
    end else if (flush) begin
      beat_cnt <= '0;
      ovf_seen <= 1'b0;
    end else begin
      if (pop && (beat_cnt != 16'hFFFF)) beat_cnt <= beat_cnt + 16'd1;
      // s_tready low means full, so this is upstream backpressure.
      if (s_tvalid && !s_tready) ovf_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_sm_fifo.sv
// -----------------------------------------------------------------------------
// tb_fir_sm_fifo
// Self-checking bench for fir_sm_fifo (default parameters: 32 bits, depth 8).
// A queue-based reference model tracks the buffer contents and flags; every
// clock is compared against it, with directed tables and sequences on top.
// -----------------------------------------------------------------------------
module tb_fir_sm_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n;
  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] s_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic          flush, frame_done, frame_clr;
  logic [CW-1:0] count;
`ifdef FIR_SM_FIFO_STATS_EN
  logic [15:0]   beat_cnt;
  logic          ovf_seen;
`endif

  always #5 axis_clk = ~axis_clk;

  fir_sm_fifo dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tdata    (s_tdata),
    .s_tlast    (s_tlast),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .flush      (flush),
    .count      (count),
    .frame_done (frame_done),
`ifdef FIR_SM_FIFO_STATS_EN
    .beat_cnt   (beat_cnt),
    .ovf_seen   (ovf_seen),
`endif
    .frame_clr  (frame_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW:0] mq[$];   // {last, data}, head at index 0
  bit          m_fd;
  int          m_beats;
  bit          m_ovf;

  task automatic model_reset();
    mq.delete();
    m_fd = 0; m_beats = 0; m_ovf = 0;
  endtask

  // Applies one clock edge of the buffer's rules to the model.
  task automatic model_step();
    bit full, do_push, do_pop, pop_last;
    full    = (mq.size() == DEPTH);
    do_push = s_tvalid && !full;
    do_pop  = m_tready && (mq.size() != 0);
    if (flush) begin
      model_reset();
    end else begin
      pop_last = do_pop && mq[0][DW];
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({s_tlast, s_tdata});
      if (pop_last) m_fd = 1;
      else if (frame_clr) m_fd = 0;
      if (do_pop && m_beats < 16'hFFFF) m_beats++;
      if (s_tvalid && full) m_ovf = 1;
    end
  endtask

  task automatic compare_model();
    check("count", 64'(count), 64'(mq.size()));
    check("s_tready", 64'(s_tready), 64'(mq.size() != DEPTH));
    check("m_tvalid", 64'(m_tvalid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("m_tdata", 64'(m_tdata), 64'(mq[0][DW-1:0]));
      check("m_tlast", 64'(m_tlast), 64'(mq[0][DW]));
    end
    check("frame_done", 64'(frame_done), 64'(m_fd));
`ifdef FIR_SM_FIFO_STATS_EN
    check("beat_cnt", 64'(beat_cnt), 64'(m_beats));
    check("ovf_seen", 64'(ovf_seen), 64'(m_ovf));
`endif
  endtask

  // One clock: model follows the edge, outputs sampled 1 ns later.
  task automatic tick();
    @(posedge axis_clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic idle();
    s_tvalid = 0; s_tdata = '0; s_tlast = 0;
    m_tready = 0; flush = 0; frame_clr = 0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic          s_tlast;
    logic          m_tready;
    logic          frame_clr;
    logic [CW-1:0] exp_count;
    logic          exp_m_tvalid;
    logic [DW-1:0] exp_data;
    logic          exp_last;
    logic          exp_fd;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    axis_rst_n = 1'b0;
    model_reset();
    #23 axis_rst_n = 1'b1;

    // Reset values
    check("rst s_tready", 64'(s_tready), 64'd1);
    check("rst m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst m_tdata", 64'(m_tdata), 64'd0);
    check("rst m_tlast", 64'(m_tlast), 64'd0);
    check("rst count", 64'(count), 64'd0);
    check("rst frame_done", 64'(frame_done), 64'd0);

    //          vld  data      last rdy  clr  cnt   mv   data      ml   fd
    vecs[0]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 32'h11, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 32'h0,  1'b0, 1'b0};
    vecs[2]  = '{1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 32'h40, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 32'h0,  1'b0, 1'b1};
    vecs[4]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 32'h0,  1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 32'h40, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 32'h0,  1'b0, 1'b1};
    vecs[7]  = '{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 32'h0,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 32'h0,  1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h5,  1'b0, 1'b1, 1'b0, 4'd1, 1'b1, 32'h5,  1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 32'h0,  1'b0, 1'b0};

    @(negedge axis_clk);
    for (int i = 0; i < 11; i++) begin
      s_tvalid  = vecs[i].s_tvalid;
      s_tdata   = vecs[i].s_tdata;
      s_tlast   = vecs[i].s_tlast;
      m_tready  = vecs[i].m_tready;
      frame_clr = vecs[i].frame_clr;
      tick();
      check($sformatf("vec%0d count", i), 64'(count), 64'(vecs[i].exp_count));
      check($sformatf("vec%0d m_tvalid", i), 64'(m_tvalid), 64'(vecs[i].exp_m_tvalid));
      if (vecs[i].exp_m_tvalid) begin
        check($sformatf("vec%0d m_tdata", i), 64'(m_tdata), 64'(vecs[i].exp_data));
        check($sformatf("vec%0d m_tlast", i), 64'(m_tlast), 64'(vecs[i].exp_last));
      end
      check($sformatf("vec%0d frame_done", i), 64'(frame_done), 64'(vecs[i].exp_fd));
    end
    idle();

    // Fill to full, hold the 9th beat, one pop admits it, drain in order
    for (int v = 1; v <= 8; v++) begin
      s_tvalid = 1; s_tdata = DW'(v);
      tick();
    end
    check("full count", 64'(count), 64'd8);
    check("full s_tready", 64'(s_tready), 64'd0);
    s_tdata = 32'd9;
    tick();
    tick();
    check("held count", 64'(count), 64'd8);
    check("head before pop", 64'(m_tdata), 64'd1);
    m_tready = 1;
    tick();
    check("pop at full ready", 64'(s_tready), 64'd1);
    check("pop at full count", 64'(count), 64'd7);
    m_tready = 0;
    tick();
    check("9th entered", 64'(count), 64'd8);
    s_tvalid = 0;
    for (int v = 2; v <= 9; v++) begin
      check($sformatf("drain %0d", v), 64'(m_tdata), 64'(v));
      m_tready = 1;
      tick();
    end
    m_tready = 0;
    check("drained count", 64'(count), 64'd0);

    // Sustained push+pop: occupancy stays at 1
    s_tvalid = 1; s_tdata = 32'd0;
    tick();
    for (int i = 1; i < 64; i++) begin
      check($sformatf("stream head %0d", i - 1), 64'(m_tdata), 64'(i - 1));
      s_tdata = DW'(i); m_tready = 1;
      tick();
      check($sformatf("stream count %0d", i), 64'(count), 64'd1);
    end
    s_tvalid = 0;
    check("stream head 63", 64'(m_tdata), 64'd63);
    tick();
    idle();

    // Flush at count=5 while pushing
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1; s_tdata = 32'hA0 + DW'(i);
      tick();
    end
    check("pre-flush count", 64'(count), 64'd5);
    s_tdata = 32'hDEAD; flush = 1;
    tick();
    idle();
    check("flush count", 64'(count), 64'd0);
    check("flush m_tvalid", 64'(m_tvalid), 64'd0);
    check("flush s_tready", 64'(s_tready), 64'd1);
    s_tvalid = 1; s_tdata = 32'h77;
    tick();
    idle();
    check("post-flush head", 64'(m_tdata), 64'h77);
    check("post-flush count", 64'(count), 64'd1);
    m_tready = 1;
    tick();
    idle();

`ifdef FIR_SM_FIFO_STATS_EN
    flush = 1;
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      s_tvalid = 1; s_tdata = DW'(i); m_tready = 0;
      tick();
      s_tvalid = 0; m_tready = 1;
      tick();
    end
    idle();
    check("stats beat_cnt 10", 64'(beat_cnt), 64'd10);
    check("stats ovf clear", 64'(ovf_seen), 64'd0);
    for (int i = 0; i < 8; i++) begin
      s_tvalid = 1; s_tdata = DW'(i);
      tick();
    end
    tick();   // s_tvalid held while full for one cycle
    idle();
    check("stats ovf_seen", 64'(ovf_seen), 64'd1);
    flush = 1;
    tick();
    idle();
    check("stats flush beat_cnt", 64'(beat_cnt), 64'd0);
    check("stats flush ovf", 64'(ovf_seen), 64'd0);
`endif

    // Randomized traffic, alternating slow and fast reader phases
    for (int i = 0; i < 2000; i++) begin
      int rdy_pct;
      rdy_pct   = ((i / 200) % 2 == 0) ? 25 : 85;
      s_tvalid  = ($urandom_range(99) < 70);
      s_tdata   = $urandom;
      s_tlast   = ($urandom_range(7) == 0);
      m_tready  = ($urandom_range(99) < rdy_pct);
      flush     = ($urandom_range(63) == 0);
      frame_clr = ($urandom_range(7) == 0);
      tick();
    end
    idle();

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1; s_tdata = 32'hC0 + DW'(i); s_tlast = 1;
      tick();
    end
    idle();
    m_tready = 1;
    tick();
    m_tready = 0;
    #2 axis_rst_n = 1'b0;
    #1;
    model_reset();
    check("async rst count", 64'(count), 64'd0);
    check("async rst s_tready", 64'(s_tready), 64'd1);
    check("async rst m_tvalid", 64'(m_tvalid), 64'd0);
    check("async rst m_tdata", 64'(m_tdata), 64'd0);
    check("async rst m_tlast", 64'(m_tlast), 64'd0);
    check("async rst frame_done", 64'(frame_done), 64'd0);
    #2 axis_rst_n = 1'b1;
    s_tvalid = 1; s_tdata = 32'h1234;
    tick();
    idle();
    check("after rst head", 64'(m_tdata), 64'h1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
